// File: rtl/serial_frame_tx_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_frame_tx_if : parallel handshake and serial line of serial_frame_tx
// Revision: 1.0
// ---------------------------------------------------------------------------
interface serial_frame_tx_if #(
  parameter int WIDTH = 8
) ();
  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             data_ready;
  logic             serial_out;
  logic             busy;
  logic             done;

  modport master (
    output data_in, data_valid,
    input  data_ready, serial_out, busy, done
  );

  modport slave (
    input  data_in, data_valid,
    output data_ready, serial_out, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/serial_frame_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_frame_tx : framed LSB-first serializer (start, data, even parity, stop)
// Revision: 1.0
// ---------------------------------------------------------------------------
module serial_frame_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter bit PARITY_EN    = 1'b0
) (
  input  logic               clk,
  input  logic               reset_n,
  serial_frame_tx_if.slave   bus
);

  localparam int c_baud_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int c_bit_w  = $clog2(WIDTH);
  localparam logic [c_baud_w-1:0] c_baud_last = c_baud_w'(CLKS_PER_BIT - 1);
  localparam logic [c_bit_w-1:0]  c_bit_last  = c_bit_w'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t              state_q,  state_d;
  logic [WIDTH-1:0]    shift_q,  shift_d;
  logic                parity_q, parity_d;
  logic [c_baud_w-1:0] baud_q,   baud_d;
  logic [c_bit_w-1:0]  bit_q,    bit_d;
  logic                serial_q, serial_d;
  logic                done_q,   done_d;
  logic                w_bit_end;

  assign w_bit_end = (baud_q == c_baud_last);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      shift_q  <= '0;
      parity_q <= 1'b0;
      baud_q   <= '0;
      bit_q    <= '0;
      serial_q <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      serial_q <= serial_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    done_d   = 1'b0;

    if (state_q != S_IDLE) begin
      baud_d = w_bit_end ? '0 : baud_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.data_valid) begin
          state_d  = S_START;
          shift_d  = bus.data_in;
          parity_d = ^bus.data_in;
          baud_d   = '0;
          bit_d    = '0;
        end
      end
      S_START: begin
        if (w_bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (w_bit_end) begin
          shift_d = {1'b0, shift_q[WIDTH-1:1]};
          if (bit_q == c_bit_last) begin
            bit_d   = '0;
            state_d = PARITY_EN ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (w_bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (w_bit_end) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Line level is decoded from the next state so serial_out stays a pure flop.
  always_comb begin
    serial_d = 1'b1;
    case (state_d)
      S_START:  serial_d = 1'b0;
      S_DATA:   serial_d = shift_d[0];
      S_PARITY: serial_d = parity_d;
      default:  serial_d = 1'b1;
    endcase
  end

  assign bus.data_ready = (state_q == S_IDLE);
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.serial_out = serial_q;
  assign bus.done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_serial_frame_tx : two configurations (8/1/no-parity, 8/4/parity) vs frame model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_serial_frame_tx;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  serial_frame_tx_if #(.WIDTH(8)) ifa ();
  serial_frame_tx_if #(.WIDTH(8)) ifb ();

  serial_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(1), .PARITY_EN(1'b0)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(ifa.slave)
  );
  serial_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1'b1)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(ifb.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Frame bit k: 0 start, 1..8 data LSB first, 9 parity when enabled, then stop.
  function automatic logic exp_bit(input logic [7:0] w, input int k, input bit par);
    if (k == 0) return 1'b0;
    if (k <= 8) return w[k-1];
    if (k == 9 && par) return ^w;
    return 1'b1;
  endfunction

  task automatic drive(input bit sel, input logic v, input logic [7:0] d);
    if (sel) begin ifb.data_valid = v; ifb.data_in = d; end
    else     begin ifa.data_valid = v; ifa.data_in = d; end
  endtask

  task automatic sample(input bit sel, output logic s, output logic r, output logic b, output logic d);
    s = sel ? ifb.serial_out : ifa.serial_out;
    r = sel ? ifb.data_ready : ifa.data_ready;
    b = sel ? ifb.busy       : ifa.busy;
    d = sel ? ifb.done       : ifa.done;
  endtask

  task automatic check_idle(input bit sel);
    logic s, r, b, d;
    sample(sel, s, r, b, d);
    check("idle_serial", s, 1'b1);
    check("idle_ready",  r, 1'b1);
    check("idle_busy",   b, 1'b0);
    check("idle_done",   d, 1'b0);
  endtask

  // Called at a negedge; transfer happens on the following posedge.
  task automatic tx_frame(input bit sel, input logic [7:0] word, input bit keep_valid, input int pulse_at);
    int cpb = sel ? 4 : 1;
    bit par = sel;
    int f   = cpb * (10 + (sel ? 1 : 0));
    int k;
    logic s, r, b, d;
    logic [7:0] sipo = 8'h00;
    drive(sel, 1'b1, word);
    sample(sel, s, r, b, d);
    check("ready_before_transfer", r, 1'b1);
    @(posedge clk);
    @(negedge clk);
    if (!keep_valid) drive(sel, 1'b0, 8'($urandom));
    for (int i = 0; i < f; i++) begin
      if (i == pulse_at) drive(sel, 1'b1, 8'($urandom));
      else if (i == pulse_at + 1) drive(sel, 1'b0, 8'($urandom));
      sample(sel, s, r, b, d);
      k = i / cpb;
      check("frame_serial", s, exp_bit(word, k, par));
      check("frame_ready",  r, 1'b0);
      check("frame_busy",   b, 1'b1);
      check("frame_done",   d, 1'b0);
      if (k >= 1 && k <= 8 && (i % cpb) == cpb / 2) sipo = {s, sipo[7:1]};
      @(negedge clk);
    end
    check("loopback_word", sipo, word);
    sample(sel, s, r, b, d);
    check("done_pulse",   d, 1'b1);
    check("done_ready",   r, 1'b1);
    check("done_serial",  s, 1'b1);
    check("done_busy",    b, 1'b0);
    if (!keep_valid) begin
      drive(sel, 1'b0, 8'($urandom));
      @(negedge clk);
      sample(sel, s, r, b, d);
      check("done_single", d, 1'b0);
      check("after_ready", r, 1'b1);
      check("after_serial", s, 1'b1);
    end
  endtask

  initial begin
    logic s, r, b, d;
    bit   sel;
    logic [7:0] w1, w2;

    drive(1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    reset_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_idle(1'b0);
      check_idle(1'b1);
    end
    reset_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check_idle(1'b0);
      check_idle(1'b1);
    end

    tx_frame(1'b0, 8'hA5, 1'b0, -1);
    tx_frame(1'b1, 8'hA5, 1'b0, -1);
    tx_frame(1'b1, 8'h07, 1'b0, -1);

    tx_frame(1'b0, 8'h3C, 1'b1, -1);
    tx_frame(1'b0, 8'hC3, 1'b0, -1);
    tx_frame(1'b1, 8'h3C, 1'b1, -1);
    tx_frame(1'b1, 8'hC3, 1'b0, -1);

    tx_frame(1'b0, 8'($urandom), 1'b0, 4);
    tx_frame(1'b1, 8'($urandom), 1'b0, 20);
    repeat (5) begin
      @(negedge clk);
      check_idle(1'b0);
      check_idle(1'b1);
    end

    // Abort a frame of 0xFF on dut_a during data bit 3.
    drive(1'b0, 1'b1, 8'hFF);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00);
    repeat (4) @(negedge clk);
    sample(1'b0, s, r, b, d);
    check("abort_busy_before", b, 1'b1);
    #2 reset_n = 1'b0;
    #1 check_idle(1'b0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_idle(1'b0);
    end
    tx_frame(1'b0, 8'h81, 1'b0, -1);

    repeat (20) begin
      sel = 1'($urandom_range(0, 1));
      w1  = 8'($urandom);
      w2  = 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        tx_frame(sel, w1, 1'b1, -1);
        tx_frame(sel, w2, 1'b0, -1);
      end else begin
        tx_frame(sel, w1, 1'b0, -1);
      end
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        check_idle(sel);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_frame_tx.md
# serial_frame_tx

Parallel-in, serial-out frame transmitter: the transmit end of the serial bit-stream that our right-shifting SISO shift registers receive. It accepts a parallel word via a valid/ready handshake and drives it onto a single line as a framed sequence: start bit, data LSB first, optional even parity, stop bit. With LSB-first ordering, a downstream right-shift register (MSB insertion) ends up holding the word in natural bit order. Sits between a parallel producer and the serial link.

## Interface
- WIDTH, 8: data word width in bits; must be ≥ 2.
- CLKS_PER_BIT, 1: clock cycles each bit is held on the line; must be ≥ 1.
- PARITY_EN, 0: 1 inserts an even-parity bit after the data bits.

- clk  input  1  rising-edge clock; the single clock of the block.
- reset_n  input  1  asynchronous, active-low reset.
- data_in  input  WIDTH  word to transmit; sampled on handshake.
- data_valid  input  1  producer has a word on data_in.
- data_ready  output  1  block can accept a word; high only in IDLE.
- serial_out  output  1  serial line; idles high.
- busy  output  1  high while a frame is in progress (any state other than IDLE).
- done  output  1  one-cycle pulse: frame complete.

## Operation
- Handshake: a transfer occurs on a rising clk edge where data_valid && data_ready.
  - On transfer, capture data_in into the shift register and compute parity as XOR of data_in.
  - data_in is don't-care when no transfer occurs. data_valid may drop without a transfer and no state changes.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on transfer.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> PARITY (if PARITY_EN) or STOP, after WIDTH bit periods.
  - PARITY -> STOP after one bit period.
  - STOP -> IDLE after one bit period.
- serial_out by state:
  - IDLE: 1.
  - START: 0.
  - DATA: shift_reg[0]; the shift register shifts right by one at the end of each bit period.
  - PARITY: even-parity bit.
  - STOP: 1.
- Counters:
  - Baud counter runs 0..CLKS_PER_BIT-1 and wraps; a bit period ends when it reaches CLKS_PER_BIT-1.
  - Bit counter runs 0..WIDTH-1 in DATA; width is clog2(WIDTH).
- data_ready = (state == IDLE). busy = !data_ready.
- done is registered: high for exactly one cycle, the first cycle back in IDLE after STOP.
- serial_out and done are registered outputs with no combinational path from inputs.
- data_valid held high continuously: a new frame is accepted in the first IDLE cycle. The line gap between frames is then one cycle of idle-high.

## Timing
- Reset (reset_n low, asynchronous, effective immediately, independent of clk):
  - state = IDLE, serial_out = 1, data_ready = 1, busy = 0, done = 0.
  - Shift register and counters are cleared.
- Reset mid-frame: the line returns high immediately and the frame is abandoned (word lost; no done pulse). After reset_n deasserts, the first transfer is possible on the next rising edge.
- Transfer edge T: serial_out = 0 (start bit) from T for CLKS_PER_BIT cycles.
- Frame length F = CLKS_PER_BIT × (WIDTH + 2 + PARITY_EN) cycles, from edge T to the edge that returns the FSM to IDLE. done is high during the cycle after that edge.
- Minimum transfer-to-transfer spacing is F + 1 cycles.
- data_ready falls on edge T and rises on the edge that enters IDLE.

## Test plan
- Reset and idle: hold reset_n low for 3 cycles, then release with data_valid = 0 for 10 cycles. Required: serial_out = 1, data_ready = 1, busy = 0, done = 0 throughout.
- Basic frame (WIDTH=8, CLKS_PER_BIT=1, PARITY_EN=0), data_in = 0xA5 with one-cycle valid. Required:
  - serial_out over 10 cycles = 0,1,0,1,0,0,1,0,1,1.
  - done pulses in cycle 11; data_ready is low for exactly 10 cycles.
- Parity and divider (PARITY_EN=1, CLKS_PER_BIT=4):
  - 0xA5: parity bit = 0; each bit is held 4 cycles; frame = 44 cycles.
  - 0x07: parity bit = 1.
- Back-to-back: data_valid held high with 0x3C then 0xC3. Required:
  - Second transfer in the cycle done is high.
  - Exactly one idle-high cycle between frames.
  - Loopback through a right-shift SIPO recovers 0x3C then 0xC3.
- Reset mid-frame: assert reset_n low during data bit 3 of 0xFF. Required:
  - serial_out = 1 within the same cycle; no done pulse.
  - The next word 0x81 is transmitted correctly after release.
- Valid withdrawn: data_valid pulsed while busy. Required: the pulse is ignored; the frame in progress is unchanged; no extra frame is sent.
